// File: rtl/ice_uart_rx_pkg.sv
// Shared types and timing helpers for the pico2-ice UART receiver.
// Package ice_uart_pkg; imported by ice_uart_rx and ice_rx_fifo.
package ice_uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    // Rounded clocks per bit so that odd ratios land on the nearest cycle.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/ice_uart_rx_fifo.sv
// Byte FIFO behind the UART receiver; a push into a full FIFO is only
// accepted when a pop happens in the same cycle, otherwise drop_o flags it.
module ice_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     drop_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             pop_do;
    logic             push_do;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign pop_do  = pop_i && !empty_o;
    // When full, the slot being written is the one the pop is vacating.
    assign push_do = push_i && (!full_o || pop_do);
    assign drop_o  = push_i && !push_do;
    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        level_d = level_q;
        if (push_do && !pop_do) begin
            level_d = level_q + 1'b1;
        end else if (!push_do && pop_do) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_do) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_do) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/ice_uart_rx.sv
// UART receiver (8N1, or 8E1 when ICE_UART_RX_PARITY_EN is defined) feeding
// a valid/ready byte stream through a small FIFO in the clk_12p0 domain.
module ice_uart_rx
    import ice_uart_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_12p0,
    input  logic                          rst_n,
    input  logic                          rx_pin,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef ICE_UART_RX_PARITY_EN
    ,
    output logic                          parity_err
`endif
);

    localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic [1:0]           sync_q;
    logic                 rxs;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q;
    logic                 push;
    logic                 pop;
    logic                 mid_bit;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_drop;
`ifdef ICE_UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_q, parity_err_d;
`endif

    assign rxs     = sync_q[1];
    assign mid_bit = (cnt_q == CNT_LAST);
    assign pop     = rx_valid && rx_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
`ifdef ICE_UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                // Half a bit in: a line that is high again was only a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        bit_d   = '0;
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (mid_bit) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_LAST) begin
`ifdef ICE_UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef ICE_UART_RX_PARITY_EN
            PARITY: begin
                if (mid_bit) begin
                    cnt_d     = '0;
                    par_bad_d = rxs ^ (^shift_q);
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (mid_bit) begin
                    cnt_d = '0;
                    if (rxs) begin
`ifdef ICE_UART_RX_PARITY_EN
                        if (par_bad_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
`else
                        push = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                // A held-low line must release before the next frame can start.
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_12p0 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef ICE_UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q      <= {sync_q[0], rx_pin};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= fifo_drop;
`ifdef ICE_UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    ice_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_12p0),
        .rst_ni  (rst_n),
        .push_i  (push),
        .data_i  (shift_q),
        .pop_i   (pop),
        .data_o  (rx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level),
        .drop_o  (fifo_drop)
    );

    assign rx_valid  = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef ICE_UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

    // Pushes only happen on a good stop bit, so the two pulses are exclusive.
    a_drop_only_when_full: assert property (
        @(posedge clk_12p0) disable iff (!rst_n) fifo_drop |-> fifo_full);
    a_err_exclusive: assert property (
        @(posedge clk_12p0) disable iff (!rst_n) !(frame_err_q && overrun_q));

endmodule

// File: tb/tb_ice_uart_rx.sv
// Directed bench for ice_uart_rx at default parameters (104 clocks per bit).
module tb_ice_uart_rx;

    localparam int BIT_CLKS = 104;

    logic       clk_12p0 = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx_pin   = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic [2:0] fifo_level;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int both_cnt = 0;
    logic [7:0] pop_q [$];

    ice_uart_rx dut (
        .clk_12p0   (clk_12p0),
        .rst_n      (rst_n),
        .rx_pin     (rx_pin),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .fifo_level (fifo_level)
    );

    always #5 clk_12p0 = ~clk_12p0;

    always @(posedge clk_12p0) begin
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (frame_err && overrun) both_cnt <= both_cnt + 1;
        if (rx_valid && rx_ready) pop_q.push_back(rx_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Leaves rx_pin at the stop-bit level when it returns.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(negedge clk_12p0);
        rx_pin = 1'b0;
        repeat (BIT_CLKS) @(negedge clk_12p0);
        for (int i = 0; i < 8; i++) begin
            rx_pin = d[i];
            repeat (BIT_CLKS) @(negedge clk_12p0);
        end
        rx_pin = stop;
        repeat (BIT_CLKS) @(negedge clk_12p0);
    endtask

    task automatic check_pop(input string tag, input logic [7:0] exp);
        logic [31:0] got;
        @(negedge clk_12p0);
        rx_ready = 1'b1;
        @(negedge clk_12p0);
        rx_ready = 1'b0;
        if (pop_q.size() == 0) got = 32'hFFFF_FFFF;
        else got = {24'h0, pop_q.pop_front()};
        check(tag, got, {24'h0, exp});
    endtask

    initial begin
        // Reset and idle
        repeat (3) @(negedge clk_12p0);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        repeat (500) @(negedge clk_12p0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_12p0);
        rst_n = 1'b1;
        repeat (500) @(negedge clk_12p0);
        check("idle_valid", rx_valid, 0);
        check("idle_data", rx_data, 0);
        check("idle_level", fifo_level, 0);
        check("idle_ferr_cnt", fe_cnt, 0);
        check("idle_ovr_cnt", ov_cnt, 0);

        // Single byte with push latency: stop sample lands 991 clocks after the start edge
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(negedge clk_12p0);
                repeat (990) @(negedge clk_12p0);
                check("a5_valid_early", rx_valid, 0);
                @(negedge clk_12p0);
                check("a5_valid_rise", rx_valid, 1);
            end
        join
        check("a5_data", rx_data, 8'hA5);
        check("a5_level", fifo_level, 1);
        check_pop("a5_pop", 8'hA5);
        check("a5_valid_after", rx_valid, 0);
        check("a5_level_after", fifo_level, 0);

        // False start
        @(negedge clk_12p0);
        rx_pin = 1'b0;
        repeat (30) @(negedge clk_12p0);
        rx_pin = 1'b1;
        repeat (300) @(negedge clk_12p0);
        check("glitch_level", fifo_level, 0);
        check("glitch_ferr_cnt", fe_cnt, 0);
        check("glitch_ovr_cnt", ov_cnt, 0);
        send_frame(8'h5A, 1'b1);
        repeat (5) @(negedge clk_12p0);
        check("glitch_next_level", fifo_level, 1);
        check_pop("glitch_next_pop", 8'h5A);

        // Framing error followed by a held-low line
        send_frame(8'h3C, 1'b0);
        repeat (5 * BIT_CLKS) @(negedge clk_12p0);
        rx_pin = 1'b1;
        repeat (300) @(negedge clk_12p0);
        check("ferr_cnt", fe_cnt, 1);
        check("ferr_level", fifo_level, 0);
        check("ferr_ovr_cnt", ov_cnt, 0);
        send_frame(8'h11, 1'b1);
        repeat (5) @(negedge clk_12p0);
        check("ferr_next_level", fifo_level, 1);
        check_pop("ferr_next_pop", 8'h11);
        check("ferr_cnt_final", fe_cnt, 1);

        // Overrun on the fifth byte
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        check("ovr_full_level", fifo_level, 4);
        check("ovr_none_yet", ov_cnt, 0);
        send_frame(8'h05, 1'b1);
        repeat (5) @(negedge clk_12p0);
        check("ovr_cnt", ov_cnt, 1);
        check("ovr_level", fifo_level, 4);
        check_pop("ovr_pop1", 8'h01);
        check_pop("ovr_pop2", 8'h02);
        check_pop("ovr_pop3", 8'h03);
        check_pop("ovr_pop4", 8'h04);
        check("ovr_level_empty", fifo_level, 0);

        // Full FIFO with a pop in the push cycle
        send_frame(8'h0A, 1'b1);
        send_frame(8'h0B, 1'b1);
        send_frame(8'h0C, 1'b1);
        send_frame(8'h0D, 1'b1);
        check("fp_full_level", fifo_level, 4);
        fork
            send_frame(8'h06, 1'b1);
            begin
                @(negedge clk_12p0);
                repeat (990) @(negedge clk_12p0);
                rx_ready = 1'b1;
                @(negedge clk_12p0);
                rx_ready = 1'b0;
            end
        join
        repeat (5) @(negedge clk_12p0);
        check("fp_ovr_cnt", ov_cnt, 1);
        check("fp_level", fifo_level, 4);
        check("fp_pop_count", pop_q.size(), 1);
        if (pop_q.size() > 0) check("fp_pop_head", pop_q.pop_front(), 8'h0A);
        check_pop("fp_pop2", 8'h0B);
        check_pop("fp_pop3", 8'h0C);
        check_pop("fp_pop4", 8'h0D);
        check_pop("fp_pop5", 8'h06);
        check("fp_level_empty", fifo_level, 0);

        check("err_exclusive", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ice_uart_rx.md
Name: ice_uart_rx

Overview:
- UART receiver for the pico2-ice FPGA. It takes the asynchronous serial line driven by the RP2350 on an ICE_* pin.
- It deserialises 8N1 frames and buffers received bytes in a small FIFO.
- It presents the bytes on a valid/ready stream to pipelinec_top, running in the clk_12p0 domain directly downstream of this block.
- Framing and overrun errors are reported as single-cycle pulses.

Parameters:
- CLK_HZ, 12000000, frequency of clk_12p0 in Hz.
- BAUD, 115200, line bit rate.
- FIFO_DEPTH, 4, byte entries in the output FIFO; must be a power of 2, at least 2.

Ports:
- clk_12p0  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_pin  in  1  raw serial line; idles high; asynchronous to clk_12p0.
- rx_data  out  8  byte at the FIFO head.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: complete byte dropped because the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.

Behaviour:
- Clock and reset: one clock, clk_12p0. Reset rst_n is asynchronous, active-low, and clears every register.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, fifo_level=0. Both synchroniser flops reset to 1 (line idle).
- Synchroniser: rx_pin passes through 2 flops to give rxs. All decisions use rxs, which adds 2 cycles of input latency.
- Bit timing: CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD, which is 104 at the defaults. HALF = CLKS_PER_BIT/2 = 52.
- Counter width: the bit counter is wide enough to hold CLKS_PER_BIT-1.
- FSM IDLE: when rxs==0, load cnt=0 and go to START.
- FSM START: when cnt==HALF-1, sample rxs.
  - If rxs==1, this is a false start: return to IDLE with no error.
  - Otherwise reset cnt and go to DATA with bit index 0.
- FSM DATA: sample rxs each time cnt==CLKS_PER_BIT-1 (mid-bit). Bits are taken LSB first into a shift register. After bit 7, go to STOP.
- FSM STOP: sample at mid-bit.
  - If rxs==1: push the byte to the FIFO and return to IDLE.
  - If rxs==0: pulse frame_err, drop the byte and go to BREAK.
- FSM BREAK: wait for rxs==1, then go to IDLE. A held-low line therefore produces exactly one frame_err.
- Push latency: the byte is written at the STOP sample edge. rx_valid is high the next cycle.
- Push on a full FIFO:
  - If a pop occurs in the same cycle, the push is accepted and the level is unchanged.
  - Otherwise the byte is dropped, overrun pulses for one cycle and the FIFO contents are unchanged.
- Pop: when rx_valid && rx_ready, the head advances at the clock edge. rx_data changes only on a pop or on a push into an empty FIFO.
- Simultaneous push and pop on an empty FIFO: not possible, because rx_valid is 0.
- Simultaneous push and pop with 0 < level < DEPTH: the level is unchanged.
- Pointers: write and read pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The level is tracked as a separate counter.
- Reset mid-frame: the FSM returns to IDLE and the FIFO is emptied. Any partial byte is discarded. No error pulses are generated.
- Error pulses: frame_err and overrun are never both high in the same cycle.

Optional Feature:
- Macro: ICE_UART_RX_PARITY_EN.
- Defined:
  - Frame format is 8E1, and a PARITY state sits between DATA and STOP.
  - The parity bit is sampled at mid-bit.
  - On a parity mismatch, the byte is dropped after a valid stop bit and output parity_err (1 bit, reset 0) pulses for one cycle.
  - If the stop bit is also low, only frame_err pulses.
- Undefined: the format is 8N1, there is no PARITY state and the parity_err port does not exist.

Decomposition:
- Package ice_uart_pkg holds:
  - typedef enum rx_state_t {IDLE, START, DATA, PARITY, STOP, BREAK};
  - a constant function clks_per_bit(CLK_HZ, BAUD);
  - localparam DATA_BITS=8.
- Sub-module ice_rx_fifo (parameters WIDTH, DEPTH) provides push, pop, full, empty and level. It owns the full-with-concurrent-pop rule.
- The FSM, synchroniser and error pulses live in ice_uart_rx.

Test Plan (defaults, 1 bit = 104 clocks):
- Idle then reset: hold rx_pin=1 for 1000 cycles with rst_n pulsed low mid-way. Every output stays 0 and fifo_level stays 0.
- Single byte: send 0xA5 in 8N1 with rx_ready=0. rx_valid rises 1 cycle after the stop-bit sample (about 9.5 bit times plus 3 cycles after the start edge). rx_data=0xA5 and fifo_level=1. Then assert rx_ready for 1 cycle: rx_valid falls and fifo_level=0.
- False start: a 30-cycle low glitch on rx_pin. No byte is pushed, no error pulses, and the FSM is back in IDLE.
- Framing error: send 0x3C with the stop bit low, then hold the line low for 5 bit times. frame_err pulses exactly once and fifo_level stays 0. A following frame 0x11 is received correctly.
- Overrun: send 5 bytes 0x01..0x05 with rx_ready=0. fifo_level=4, overrun pulses once on byte 0x05, and the pops return 0x01..0x04 in order.
- Full plus simultaneous pop: with the FIFO full, assert rx_ready in the exact cycle the byte 0x06 is pushed. No overrun, fifo_level stays 4, and the last entry read is 0x06.
